uart_cmd_rx: RTL
================

UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 60000000, meaning the sys_clk frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, meaning the serial baud rate.
REQ-003 SHALL derive the local constant BAUD_DIV = CLK_FREQ/UART_BPS, integer floor (520 at defaults).
REQ-004 SHALL have parameter HDR, default 8'hA5, meaning the frame header byte.
REQ-005 SHALL have parameter TIMEOUT_BITS, default 20, meaning the inter-byte timeout in bit periods.
REQ-006 sys_clk  input  1  single clock; all logic on the rising edge.
REQ-007 sys_rst  input  1  reset; synchronous and active-high.
REQ-008 uart_rxd  input  1  asynchronous serial line, idle high.
REQ-009 rx_byte  output  8  last byte received.
REQ-010 rx_byte_valid  output  1  one-cycle pulse; rx_byte is new.
REQ-011 cmd  output  8  command code of the last good frame.
REQ-012 cmd_data  output  16  payload of the last good frame, {DATA_H, DATA_L}.
REQ-013 cmd_valid  output  1  one-cycle pulse; cmd and cmd_data are updated.
REQ-014 frame_err  output  1  one-cycle pulse; stop bit was low.
REQ-015 chk_err  output  1  one-cycle pulse; checksum mismatch.
REQ-016 timeout_err  output  1  one-cycle pulse; partial frame was abandoned.

Function
REQ-017 uart_rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1; all logic uses the synchronized value.
REQ-018 Byte receiver FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START on a 1->0 transition of the synchronized line.
REQ-019 In START, SHALL sample the line BAUD_DIV/2 cycles after the falling edge.
- Low: go to DATA.
- High: false start; return to IDLE with no output.
REQ-020 In DATA, SHALL sample every BAUD_DIV cycles, 8 bits, LSB first; bit counter 0..7, then go to STOP.
REQ-021 In STOP, SHALL sample at the stop-bit mid-point, then return to IDLE immediately, so a back-to-back start edge is accepted.
REQ-022 Good stop bit (1): SHALL assert rx_byte_valid for one cycle in the cycle after the stop sample, with rx_byte updated in that same cycle.
REQ-023 Bad stop bit (0): SHALL assert frame_err for one cycle in place of rx_byte_valid; rx_byte SHALL be unchanged and the parser SHALL return to P_HDR.
REQ-024 Frame parser FSM SHALL have states P_HDR, P_CMD, P_DH, P_DL, P_CHK and SHALL advance one state per rx_byte_valid.
REQ-025 In P_HDR, a byte equal to HDR SHALL advance to P_CMD; any other byte SHALL be ignored silently.
REQ-026 The checksum SHALL be the 8-bit XOR of CMD, DATA_H and DATA_L.
REQ-027 In P_CHK, on a match SHALL:
- pulse cmd_valid for one cycle, in the cycle after the checksum byte's rx_byte_valid;
- update cmd and cmd_data in that same cycle;
- return to P_HDR.
REQ-028 In P_CHK, on a mismatch SHALL pulse chk_err with the same timing as cmd_valid, leave cmd and cmd_data unchanged, and return to P_HDR.
REQ-029 cmd and cmd_data SHALL hold their values until the next cmd_valid.
REQ-030 Timeout counter: SHALL clear on every rx_byte_valid and increment while the parser is not in P_HDR.
- On reaching TIMEOUT_BITS*BAUD_DIV cycles: SHALL pulse timeout_err for one cycle and return the parser to P_HDR.
- SHALL stay cleared while the parser is in P_HDR.
REQ-031 Simultaneous rx_byte_valid and timeout expiry: the byte SHALL win, the counter SHALL clear, and no timeout_err SHALL be raised.
REQ-032 cmd_valid, chk_err, frame_err and timeout_err SHALL be mutually exclusive in any cycle.
REQ-033 Counters SHALL be sized to hold BAUD_DIV and TIMEOUT_BITS*BAUD_DIV without wrap-around.

Reset
REQ-034 With sys_rst high at a clock edge, SHALL set both FSMs to IDLE/P_HDR and clear all counters.
REQ-035 Reset values SHALL be: rx_byte=0, cmd=0, cmd_data=0; all pulse outputs 0; synchronizer flops 1.
REQ-036 Reset asserted mid-byte or mid-frame SHALL discard the partial data; after release, the first valid start edge SHALL be received normally.

Verification
REQ-037 Frame A5 12 34 56 (chk 12^34^56=70) sent as A5 12 34 56 70 -> exactly one cmd_valid, cmd=12, cmd_data=3456; no error pulses.
REQ-038 Same frame with checksum 71 -> one chk_err pulse; no cmd_valid; cmd and cmd_data keep their previous values.
REQ-039 A 200-cycle low glitch on idle uart_rxd (less than BAUD_DIV/2=260) -> no rx_byte_valid and no frame_err.
REQ-040 Byte 55 with stop bit forced 0 inside a frame -> frame_err; parser back in P_HDR; the following full valid frame decodes correctly.
REQ-041 Send A5 01, then idle for 21 bit periods -> one timeout_err; the next full frame decodes.
REQ-042 sys_rst pulsed during the DATA_H byte -> outputs return to reset values; a frame sent after release decodes with cmd_valid.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
//
// 8N1 UART receiver with a small command-frame parser on top.
// A frame has the form HDR, CMD, DATA_H, DATA_L, CHK, where CHK = CMD ^ DATA_H ^ DATA_L.
// A good frame updates cmd/cmd_data and pulses cmd_valid. A bad checksum pulses chk_err.
// A bad stop bit pulses frame_err. A partial frame that stalls too long pulses timeout_err.
//
// Parameters
//   CLK_FREQ      sys_clk frequency in Hz
//   UART_BPS      serial baud rate
//   HDR           frame header byte
//   TIMEOUT_BITS  allowed inter-byte silence inside a frame, in bit periods
//
// Ports
//   sys_clk        clock; all logic runs on the rising edge
//   sys_rst        synchronous, active-high reset
//   uart_rxd       asynchronous serial input, idle high
//   rx_byte        last byte received with a good stop bit
//   rx_byte_valid  one-cycle pulse; rx_byte is new
//   cmd, cmd_data  command and {DATA_H, DATA_L} of the last good frame
//   cmd_valid      one-cycle pulse; cmd and cmd_data were updated
//   frame_err      one-cycle pulse; stop bit was low
//   chk_err        one-cycle pulse; checksum mismatch
//   timeout_err    one-cycle pulse; a partial frame was abandoned
// -----------------------------------------------------------------------------
module uart_cmd_rx #(
    parameter int          CLK_FREQ     = 60000000,
    parameter int          UART_BPS     = 115200,
    parameter logic [7:0]  HDR          = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [7:0]  cmd,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        chk_err,
    output logic        timeout_err
);

    localparam int BAUD_DIV = CLK_FREQ / UART_BPS;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int BAUD_W   = $clog2(BAUD_DIV + 1);
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer plus one history flop for falling-edge detection
    // ------------------------------------------------------------------
    logic rxd_meta, rxd_sync, rxd_prev;
    logic rxd_fall;

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before the clock edge.
        if (sys_rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign rxd_fall = rxd_prev & ~rxd_sync;

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    rx_state_e         rx_state, rx_next;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              tick;       // sample point of the current bit
    logic              stop_tick;  // sample point of the stop bit

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // can leave it unassigned and infer a latch.
        rx_next = rx_state;
        tick    = 1'b0;
        unique case (rx_state)
            IDLE:  if (rxd_fall) rx_next = START;
            START: if (baud_cnt == HALF_LAST) begin
                       tick    = 1'b1;
                       rx_next = rxd_sync ? IDLE : DATA;   // high here is a false start
                   end
            DATA:  if (baud_cnt == BAUD_LAST) begin
                       tick = 1'b1;
                       if (bit_cnt == 3'd7) rx_next = STOP;
                   end
            STOP:  if (baud_cnt == BAUD_LAST) begin
                       tick    = 1'b1;
                       rx_next = IDLE;   // leave mid stop bit so a back-to-back start is caught
                   end
            default: rx_next = IDLE;
        endcase
    end

    assign stop_tick = tick && (rx_state == STOP);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state      <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            rx_state      <= rx_next;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;

            if (rx_state == IDLE || tick) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;

            if (rx_state == IDLE) bit_cnt <= '0;
            else if (tick && rx_state == DATA) begin
                shift   <= {rxd_sync, shift[7:1]};   // LSB arrives first
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (stop_tick) begin
                if (rxd_sync) begin
                    rx_byte       <= shift;
                    rx_byte_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame parser and inter-byte timeout
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {P_HDR, P_CMD, P_DH, P_DL, P_CHK} p_state_e;

    p_state_e        p_state, p_next;
    logic [7:0]      cmd_buf, dh_buf, dl_buf;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;

    // A stop-bit sample in flight defers expiry by one cycle. The byte or
    // frame error that follows then takes priority, and the pulses stay
    // mutually exclusive.
    always_comb begin
        p_next = p_state;
        to_hit = (p_state != P_HDR) && (to_cnt == TO_LAST) &&
                 !rx_byte_valid && !frame_err && !stop_tick;
        if (frame_err || to_hit) begin
            p_next = P_HDR;
        end else if (rx_byte_valid) begin
            unique case (p_state)
                P_HDR:   if (rx_byte == HDR) p_next = P_CMD;
                P_CMD:   p_next = P_DH;
                P_DH:    p_next = P_DL;
                P_DL:    p_next = P_CHK;
                default: p_next = P_HDR;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            p_state     <= P_HDR;
            cmd_buf     <= '0;
            dh_buf      <= '0;
            dl_buf      <= '0;
            cmd         <= '0;
            cmd_data    <= '0;
            cmd_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            p_state     <= p_next;
            cmd_valid   <= 1'b0;
            chk_err     <= 1'b0;
            timeout_err <= to_hit;

            if (rx_byte_valid) begin
                unique case (p_state)
                    P_CMD: cmd_buf <= rx_byte;
                    P_DH:  dh_buf  <= rx_byte;
                    P_DL:  dl_buf  <= rx_byte;
                    P_CHK: begin
                        if ((cmd_buf ^ dh_buf ^ dl_buf) == rx_byte) begin
                            cmd_valid <= 1'b1;
                            cmd       <= cmd_buf;
                            cmd_data  <= {dh_buf, dl_buf};
                        end else begin
                            chk_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Saturates at the limit so a deferred expiry cannot wrap.
            if (rx_byte_valid || frame_err || to_hit || p_state == P_HDR) to_cnt <= '0;
            else if (to_cnt != TO_LAST)                                    to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule
